alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops, a WIDTH-cycle shift-add multiply,
// registered result and {C,N,Z} flags held until the consumer takes them.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_NOT  = 4'h1;
    localparam logic [3:0] OP_PASS = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_DEC  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_SETC = 4'hB;
    localparam logic [3:0] OP_CLRC = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             load_alu;
    logic             start_mul;
    logic             load_mul;
    logic             mul_last;
    logic [CNT_W-1:0] mul_cnt;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [WIDTH-1:0] mul_sum;
    logic [2:0]       mul_flags;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_zn_upd;
    logic [2:0]       alu_flags;
    logic [WIDTH:0]   ext;
    logic [SHW-1:0]   amt;
    logic             amt_big;

    assign amt     = op2[SHW-1:0];
    assign amt_big = ({1'b0, amt} >= (SHW+1)'(WIDTH));

    // Single-cycle datapath; ext carries the carry/borrow or shifted-out bit.
    always_comb begin
        alu_res    = '0;
        alu_c      = flags[2];
        alu_zn_upd = 1'b1;
        ext        = '0;
        case (alu_mode)
            OP_ADD: begin
                ext     = {1'b0, op1} + {1'b0, op2};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_NOT:  alu_res = ~op1;
            OP_PASS: begin
                alu_res    = op1;
                alu_zn_upd = 1'b0;
            end
            OP_SUB: begin
                ext     = {1'b0, op1} - {1'b0, op2};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_INC: begin
                ext     = {1'b0, op1} + (WIDTH+1)'(1);
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_DEC: begin
                ext     = {1'b0, op1} - (WIDTH+1)'(1);
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SHL: begin
                if (amt_big) begin
                    alu_c = 1'b0;
                end else if (amt == '0) begin
                    alu_res = op1;
                end else begin
                    ext     = {1'b0, op1} << amt;
                    alu_res = ext[WIDTH-1:0];
                    alu_c   = ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (amt_big) begin
                    alu_c = 1'b0;
                end else if (amt == '0) begin
                    alu_res = op1;
                end else begin
                    ext     = {op1, 1'b0} >> amt;
                    alu_res = ext[WIDTH:1];
                    alu_c   = ext[0];
                end
            end
            OP_SETC: begin
                alu_c      = 1'b1;
                alu_zn_upd = 1'b0;
            end
            OP_CLRC: begin
                alu_c      = 1'b0;
                alu_zn_upd = 1'b0;
            end
            default: alu_zn_upd = 1'b0;
        endcase
        alu_flags = {alu_c,
                     alu_zn_upd ? alu_res[WIDTH-1] : flags[1],
                     alu_zn_upd ? (alu_res == '0)  : flags[0]};
    end

    assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_flags = {flags[2], mul_sum[WIDTH-1], mul_sum == '0};
    assign mul_last  = (state == MUL) && (mul_cnt == CNT_W'(WIDTH-1));

    assign out_valid = (state == OUT);
    assign accept    = in_valid & in_ready;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            OUT:     in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (flush || !rst_n) begin
            in_ready = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        load_alu   = accept && (alu_mode != OP_MUL);
        start_mul  = accept && (alu_mode == OP_MUL);
        load_mul   = mul_last && !flush;
        case (state)
            IDLE: begin
                if (accept) state_next = start_mul ? MUL : OUT;
            end
            MUL: begin
                if (mul_last) state_next = OUT;
            end
            OUT: begin
                if (accept)         state_next = start_mul ? MUL : OUT;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Control and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mul_cnt <= '0;
            result  <= '0;
            flags   <= 3'b000;
        end else begin
            state <= state_next;
            if (start_mul || flush || mul_last) begin
                mul_cnt <= '0;
            end else if (state == MUL) begin
                mul_cnt <= mul_cnt + 1'b1;
            end
            if (load_alu) begin
                result <= alu_res;
                flags  <= alu_flags;
            end else if (load_mul) begin
                result <= mul_sum;
                flags  <= mul_flags;
            end
        end
    end

    // Multiplier datapath: one multiplier bit consumed per MUL cycle.
    always_ff @(posedge clk) begin
        if (start_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= op1;
            mul_mplier <= op2;
        end else if (state == MUL) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
        end
    end

endmodule
